// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl -- single-issue controller for an external combinational ALU.
//
// Accepts one RV32 R-type (AND/OR/ADD/SUB) or I-type (ANDI/ORI/ADDI)
// instruction at a time, registers the ALU opcode and operands, waits
// RESULT_WAIT cycles for the ALU result, then presents it on a
// valid/ready writeback port. Writes to x0 complete without a writeback.
//
// Optional feature macro: ALU_ISSUE_ILLEGAL_EN
//   defined   : adds the 'illegal' output; illegal instructions produce a
//               writeback with illegal=1 and wb_data=0.
//   undefined : illegal instructions are consumed silently.
//
// Parameters
//   RESULT_WAIT  cycles spent in EXEC before result capture (1..4)
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   instr_valid/instr_ready  instruction handshake (ready only when idle)
//   instr                    RV32 instruction word
//   rs1_data, rs2_data       register operands, sampled at acceptance
//   alu_op, alu_a, alu_b     registered ALU controls/operands
//   alu_result               combinational ALU output
//   wb_valid/wb_ready        writeback handshake
//   wb_rd, wb_data           writeback destination and value
//   illegal                  illegal-instruction flag (feature macro only)
module alu_issue_ctrl #(
  parameter int unsigned RESULT_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
`ifdef ALU_ISSUE_ILLEGAL_EN
  ,
  output logic        illegal
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  localparam logic [1:0] CNT_INIT = 2'(RESULT_WAIT - 1);

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [4:0]  r_rd;
  logic [3:0]  r_alu_op;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic        r_illegal;
`endif

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_legal;
  logic [3:0]  w_op;
  logic [31:0] w_b;
  logic        w_unused_rs1_field;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];

  // rs1/rs2 index fields are resolved upstream; operands arrive as data.
  assign w_unused_rs1_field = &{1'b0, instr[19:15]};

  always_comb begin
    w_legal = 1'b0;
    w_op    = '0;
    w_b     = rs2_data;
    case (w_opcode)
      7'b0110011: begin
        if (w_funct7 == 7'b0000000) begin
          case (w_funct3)
            3'b111:  begin w_legal = 1'b1; w_op = OP_AND; end
            3'b110:  begin w_legal = 1'b1; w_op = OP_OR;  end
            3'b000:  begin w_legal = 1'b1; w_op = OP_ADD; end
            default: w_legal = 1'b0;
          endcase
        end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
          w_legal = 1'b1;
          w_op    = OP_SUB;
        end
      end
      7'b0010011: begin
        w_b = {{20{instr[31]}}, instr[31:20]};
        case (w_funct3)
          3'b111:  begin w_legal = 1'b1; w_op = OP_AND; end
          3'b110:  begin w_legal = 1'b1; w_op = OP_OR;  end
          3'b000:  begin w_legal = 1'b1; w_op = OP_ADD; end
          default: w_legal = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rd       <= '0;
      r_alu_op   <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
`ifdef ALU_ISSUE_ILLEGAL_EN
      r_illegal  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            if (w_legal) begin
              r_alu_op <= w_op;
              r_alu_a  <= rs1_data;
              r_alu_b  <= w_b;
              r_rd     <= instr[11:7];
              r_cnt    <= CNT_INIT;
              r_state  <= S_EXEC;
            end
`ifdef ALU_ISSUE_ILLEGAL_EN
            else begin
              // Illegal instructions bypass EXEC and leave ALU controls untouched.
              r_wb_valid <= 1'b1;
              r_wb_rd    <= instr[11:7];
              r_wb_data  <= '0;
              r_illegal  <= 1'b1;
              r_state    <= S_WB;
            end
`endif
          end
        end
        S_EXEC: begin
          if (r_cnt == 2'd0) begin
            if (r_rd != 5'd0) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_data  <= alu_result;
              r_state    <= S_WB;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_WB: begin
          if (wb_ready) begin
            r_wb_valid <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
            r_illegal  <= 1'b0;
`endif
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign alu_op      = r_alu_op;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign wb_valid    = r_wb_valid;
  assign wb_rd       = r_wb_rd;
  assign wb_data     = r_wb_data;
`ifdef ALU_ISSUE_ILLEGAL_EN
  assign illegal     = r_illegal;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: u_dut uses RESULT_WAIT=1 for the functional
// vectors, u_dut4 uses RESULT_WAIT=4 for latency and mid-EXEC reset.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---- u_dut signals
  logic        rst, instr_valid, instr_ready, wb_valid, wb_ready;
  logic [31:0] instr, rs1_data, rs2_data, alu_a, alu_b, alu_result, wb_data;
  logic [3:0]  alu_op;
  logic [4:0]  wb_rd;
  // ---- u_dut4 signals
  logic        rst_4, instr_valid_4, instr_ready_4, wb_valid_4, wb_ready_4;
  logic [31:0] instr_4, rs1_data_4, rs2_data_4, alu_a_4, alu_b_4, alu_result_4, wb_data_4;
  logic [3:0]  alu_op_4;
  logic [4:0]  wb_rd_4;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic        illegal, illegal_4;
`endif

  int total = 0;
  int bad   = 0;

  // External ALU behaviour
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      default: return 32'h0;
    endcase
  endfunction

  assign alu_result   = alu_model(alu_op, alu_a, alu_b);
  assign alu_result_4 = alu_model(alu_op_4, alu_a_4, alu_b_4);

  alu_issue_ctrl u_dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef ALU_ISSUE_ILLEGAL_EN
    , .illegal(illegal)
`endif
  );

  alu_issue_ctrl #(.RESULT_WAIT(4)) u_dut4 (
    .clk(clk), .rst(rst_4), .instr_valid(instr_valid_4), .instr_ready(instr_ready_4),
    .instr(instr_4), .rs1_data(rs1_data_4), .rs2_data(rs2_data_4),
    .alu_op(alu_op_4), .alu_a(alu_a_4), .alu_b(alu_b_4), .alu_result(alu_result_4),
    .wb_valid(wb_valid_4), .wb_ready(wb_ready_4), .wb_rd(wb_rd_4), .wb_data(wb_data_4)
`ifdef ALU_ISSUE_ILLEGAL_EN
    , .illegal(illegal_4)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // ---- scoreboard
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ill;
  } wb_t;
  wb_t exp_q[$];

  always @(negedge clk) begin
    wb_t e;
    if (!rst && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wb: got rd=%0d data=0x%0h want no writeback", wb_rd, wb_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        check("sb_wb_data", wb_data, e.data);
`ifdef ALU_ISSUE_ILLEGAL_EN
        check("sb_illegal", {31'd0, illegal}, {31'd0, e.ill});
`endif
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!instr_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!instr_ready) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Called at posedge+1; returns at accepting edge+1 with inputs scrambled.
  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    instr_valid = 1'b1;
    instr       = ins;
    rs1_data    = a;
    rs2_data    = b;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr       = $urandom;
    rs1_data    = $urandom;
    rs2_data    = $urandom;
  endtask

  // Directed vectors: instr, rs1, rs2, alu_op, alu_b, rd, data
  typedef struct {
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] bval;
    logic [4:0]  rd;
    logic [31:0] data;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h402081B3, 32'd5,        32'd7,        4'b0110, 32'd7,        5'd3, 32'hFFFFFFFE};
    vecs[1] = '{32'hFFF00093, 32'd0,        32'hDEADBEEF, 4'b0010, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFF};
    vecs[2] = '{32'h0020F1B3, 32'h0000F0F0, 32'h0000FF00, 4'b0000, 32'h0000FF00, 5'd3, 32'h0000F000};
    vecs[3] = '{32'h0020E1B3, 32'h0000F0F0, 32'h0000FF00, 4'b0001, 32'h0000FF00, 5'd3, 32'h0000FFF0};
    vecs[4] = '{32'h0FF0E113, 32'h00000100, 32'h0000AAAA, 4'b0001, 32'h000000FF, 5'd2, 32'h000001FF};
    vecs[5] = '{32'h8000F193, 32'h12345FFF, 32'h00005555, 4'b0000, 32'hFFFFF800, 5'd3, 32'h12345800};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ill_ins[2];
    logic [31:0] tmp;
    int n;
    int seen;

    rst = 1'b1; rst_4 = 1'b1;
    instr_valid = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0; wb_ready = 1'b0;
    instr_valid_4 = 1'b0; instr_4 = '0; rs1_data_4 = '0; rs2_data_4 = '0; wb_ready_4 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // reset state
    check("rst_alu_op", {28'd0, alu_op}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    rst = 1'b0; rst_4 = 1'b0;
    @(posedge clk); #1;
    check("rst_instr_ready", {31'd0, instr_ready}, 32'd1);

    // ADD with one-cycle latency and wb_ready already high
    wb_ready = 1'b1;
    exp_q.push_back('{5'd3, 32'd12, 1'b0});
    issue(32'h002081B3, 32'd5, 32'd7);
    check("add_alu_op", {28'd0, alu_op}, 32'h2);
    check("add_alu_a", alu_a, 32'd5);
    check("add_alu_b", alu_b, 32'd7);
    check("add_busy_ready", {31'd0, instr_ready}, 32'd0);
    @(posedge clk); #1;
    check("add_latency", {31'd0, wb_valid}, 32'd1);
    @(posedge clk); #1;
    check("add_wb_done", {31'd0, wb_valid}, 32'd0);
    check("add_back_idle", {31'd0, instr_ready}, 32'd1);

    // remaining directed vectors
    foreach (vecs[i]) begin
      exp_q.push_back('{vecs[i].rd, vecs[i].data, 1'b0});
      issue(vecs[i].ins, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_alu_op", i), {28'd0, alu_op}, {28'd0, vecs[i].op});
      check($sformatf("vec%0d_alu_b", i), alu_b, vecs[i].bval);
      wait_idle();
    end

    // backpressure: 5 stalled cycles, new instructions offered meanwhile
    wb_ready = 1'b0;
    exp_q.push_back('{5'd3, 32'd12, 1'b0});
    issue(32'h002081B3, 32'd5, 32'd7);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      instr_valid = 1'b1;
      instr       = 32'h0020E1B3;
      rs1_data    = 32'h11111111;
      rs2_data    = 32'h22222222;
      check("bp_wb_valid", {31'd0, wb_valid}, 32'd1);
      check("bp_wb_data", wb_data, 32'd12);
      check("bp_instr_ready", {31'd0, instr_ready}, 32'd0);
      @(posedge clk); #1;
    end
    check("bp_no_accept", {28'd0, alu_op}, 32'h2);
    instr_valid = 1'b0;
    wb_ready    = 1'b1;
    @(posedge clk); #1;
    check("bp_released", {31'd0, wb_valid}, 32'd0);
    check("bp_idle", {31'd0, instr_ready}, 32'd1);

    // rd = x0: no writeback
    issue(32'h00208033, 32'd1, 32'd2);
    check("rd0_alu_op", {28'd0, alu_op}, 32'h2);
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (wb_valid) seen++;
    end
    check("rd0_no_wb", seen, 32'd0);
    check("rd0_idle", {31'd0, instr_ready}, 32'd1);

    // illegal encodings
    ill_ins[0] = 32'h0000007F;
    ill_ins[1] = 32'h4020F1B3;
    foreach (ill_ins[i]) begin
      tmp = ill_ins[i];
`ifdef ALU_ISSUE_ILLEGAL_EN
      exp_q.push_back('{tmp[11:7], 32'd0, 1'b1});
      issue(tmp, 32'h33, 32'h44);
      check($sformatf("ill%0d_flag", i), {31'd0, illegal}, 32'd1);
      check($sformatf("ill%0d_wb_valid", i), {31'd0, wb_valid}, 32'd1);
      check($sformatf("ill%0d_alu_op_kept", i), {28'd0, alu_op}, 32'h2);
      @(posedge clk); #1;
      check($sformatf("ill%0d_flag_clear", i), {31'd0, illegal}, 32'd0);
`else
      issue(tmp, 32'h33, 32'h44);
      check($sformatf("ill%0d_ready", i), {31'd0, instr_ready}, 32'd1);
      check($sformatf("ill%0d_alu_a_kept", i), alu_a, 32'd1);
      seen = 0;
      repeat (3) begin
        @(posedge clk); #1;
        if (wb_valid) seen++;
      end
      check($sformatf("ill%0d_no_wb", i), seen, 32'd0);
`endif
    end

    // RESULT_WAIT=4 latency
    instr_valid_4 = 1'b1; instr_4 = 32'h002081B3; rs1_data_4 = 32'd5; rs2_data_4 = 32'd7;
    @(posedge clk); #1;
    instr_valid_4 = 1'b0;
    n = 0;
    while (!wb_valid_4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("rw4_latency", n, 32'd4);
    check("rw4_wb_data", wb_data_4, 32'd12);
    @(posedge clk); #1;

    // reset asserted mid-EXEC
    instr_valid_4 = 1'b1; instr_4 = 32'h402081B3; rs1_data_4 = 32'd9; rs2_data_4 = 32'd3;
    @(posedge clk); #1;
    instr_valid_4 = 1'b0;
    @(posedge clk); #1;
    rst_4 = 1'b1;
    #1;
    check("mid_rst_alu_op", {28'd0, alu_op_4}, 32'd0);
    check("mid_rst_alu_a", alu_a_4, 32'd0);
    check("mid_rst_alu_b", alu_b_4, 32'd0);
    check("mid_rst_wb_valid", {31'd0, wb_valid_4}, 32'd0);
    check("mid_rst_wb_rd", {27'd0, wb_rd_4}, 32'd0);
    check("mid_rst_wb_data", wb_data_4, 32'd0);
    @(posedge clk); #1;
    rst_4 = 1'b0;
    check("mid_rst_ready", {31'd0, instr_ready_4}, 32'd1);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (wb_valid_4) seen++;
    end
    check("mid_rst_no_wb", seen, 32'd0);

    @(posedge clk); #1;
    check("sb_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
